// File: rtl/dc_fill_ctrl_pkg.sv
// dc_fill_ctrl_pkg: shared widths and FSM encoding for the D-cache fill controller.
package dc_fill_ctrl_pkg;
    localparam int LINE_W = 128;
    localparam int BEAT_W = 32;
    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int IDX_W  = 5;
    localparam int TAG_W  = 23;
    localparam int NBYTES = LINE_W / 8;
    localparam int CNT_W  = $clog2(NBEATS);
    localparam int ADDR_W = TAG_W + IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_BEAT  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;
endpackage

// File: rtl/dc_fill_ctrl_line_merge.sv
// dc_line_merge: per-byte select of pending store bytes over the fetched fill line.
module dc_line_merge
    import dc_fill_ctrl_pkg::*;
(
    input  logic [LINE_W-1:0] fill_line,
    input  logic [NBYTES-1:0] st_mask,
    input  logic [LINE_W-1:0] st_data,
    output logic [LINE_W-1:0] line
);
    genvar b;
    generate
        for (b = 0; b < NBYTES; b++) begin : g_byte
            assign line[8*b +: 8] = st_mask[b] ? st_data[8*b +: 8] : fill_line[8*b +: 8];
        end
    endgenerate
endmodule

// File: rtl/dc_fill_ctrl.sv
// dc_fill_ctrl: fetches a missed line in 4 beats, merges pending store bytes and writes it
// to the data store in one cycle; store hits share the write port outside the WRITE cycle.
module dc_fill_ctrl
    import dc_fill_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_req,
    input  logic [IDX_W-1:0]  miss_idx,
    input  logic [TAG_W-1:0]  miss_tag,
    input  logic              miss_st,
    input  logic [NBYTES-1:0] miss_st_mask,
    input  logic [LINE_W-1:0] miss_st_data,
    output logic              miss_ack,
    input  logic              st_hit_req,
    input  logic [IDX_W-1:0]  st_hit_idx,
    input  logic [NBYTES-1:0] st_hit_mask,
    input  logic [LINE_W-1:0] st_hit_data,
    output logic              st_hit_ack,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [BEAT_W-1:0] mem_rdata,
    output logic [IDX_W-1:0]  index,
    output logic [NBYTES-1:0] dc_wr_mask,
    output logic [LINE_W-1:0] dc_write_data,
    output logic              fill_busy,
    output logic              fill_done
);
    state_e                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NBYTES-1:0]              st_mask_q, st_mask_d;
    logic [LINE_W-1:0]              st_data_q, st_data_d;
    logic [NBEATS-1:0][BEAT_W-1:0]  fill_q, fill_d;
    logic [ADDR_W-1:0]              mem_addr_q, mem_addr_d;
    logic                           mem_req_q, mem_req_d;
    logic                           miss_ack_q, miss_ack_d;
    logic                           st_hit_ack_q, st_hit_ack_d;
    logic [IDX_W-1:0]               index_q, index_d;
    logic [NBYTES-1:0]              wr_mask_q, wr_mask_d;
    logic [LINE_W-1:0]              wr_data_q, wr_data_d;
    logic                           fill_busy_q, fill_busy_d;
    logic                           fill_done_q, fill_done_d;
    logic [LINE_W-1:0]              merged;

    dc_line_merge u_merge (
        .fill_line (fill_q),
        .st_mask   (st_mask_q),
        .st_data   (st_data_q),
        .line      (merged)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        st_mask_d    = st_mask_q;
        st_data_d    = st_data_q;
        fill_d       = fill_q;
        mem_addr_d   = mem_addr_q;
        miss_ack_d   = 1'b0;
        st_hit_ack_d = 1'b0;
        index_d      = index_q;
        wr_mask_d    = '1;
        wr_data_d    = wr_data_q;
        fill_done_d  = 1'b0;
        // The write port belongs to the fill only in WRITE; elsewhere a store hit takes it.
        if (st_hit_req && state_q != ST_WRITE) begin
            st_hit_ack_d = 1'b1;
            index_d      = st_hit_idx;
            wr_mask_d    = ~st_hit_mask;
            wr_data_d    = st_hit_data;
        end
        unique case (state_q)
            ST_IDLE: if (miss_req && !st_hit_req) begin
                idx_d      = miss_idx;
                st_mask_d  = miss_st ? miss_st_mask : '0;
                st_data_d  = miss_st_data;
                mem_addr_d = {miss_tag, miss_idx};
                miss_ack_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_REQ;
            end
            ST_REQ: if (mem_gnt) state_d = ST_BEAT;
            ST_BEAT: if (mem_rvalid) begin
                fill_d[cnt_q] = mem_rdata;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NBEATS - 1)) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                index_d     = idx_q;
                wr_mask_d   = '0;
                wr_data_d   = merged;
                fill_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        mem_req_d   = state_d == ST_REQ;
        fill_busy_d = state_d != ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            st_mask_q    <= '0;
            st_data_q    <= '0;
            fill_q       <= '0;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            miss_ack_q   <= 1'b0;
            st_hit_ack_q <= 1'b0;
            index_q      <= '0;
            wr_mask_q    <= '1;
            wr_data_q    <= '0;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            st_mask_q    <= st_mask_d;
            st_data_q    <= st_data_d;
            fill_q       <= fill_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
            miss_ack_q   <= miss_ack_d;
            st_hit_ack_q <= st_hit_ack_d;
            index_q      <= index_d;
            wr_mask_q    <= wr_mask_d;
            wr_data_q    <= wr_data_d;
            fill_busy_q  <= fill_busy_d;
            fill_done_q  <= fill_done_d;
        end
    end

    assign miss_ack      = miss_ack_q;
    assign st_hit_ack    = st_hit_ack_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign index         = index_q;
    assign dc_wr_mask    = wr_mask_q;
    assign dc_write_data = wr_data_q;
    assign fill_busy     = fill_busy_q;
    assign fill_done     = fill_done_q;
endmodule
